mu0_control: RTL and testbench
==============================

MU0_CONTROL -- requirements
Module: mu0_control

Interface
REQ-001 clk  input  1  rising-edge system clock; all state changes on this edge.
REQ-002 rst_n  input  1  reset; asynchronous, active-low.
REQ-003 F  input  4  opcode field IR[15:12] from the instruction register.
REQ-004 N  input  1  accumulator negative flag (Acc[15]).
REQ-005 Z  input  1  accumulator zero flag (Acc==0).
REQ-006 mem_ready  input  1  memory completes the current MEMrq access this cycle.
REQ-007 Addr_sel  output  1  select for the 12-bit address mux: 0=PC (channel A), 1=IR[11:0] (channel B).
REQ-008 X_sel  output  1  ALU X operand: 0=Acc, 1=PC.
REQ-009 Y_sel  output  1  ALU Y operand: 0=memory data, 1=IR.
REQ-010 ALU_fs  output  2  ALU function: 00=Y, 01=X+Y, 10=X+1, 11=X-Y.
REQ-011 PC_En, IR_En, Acc_En  output  1 each  register load enables, effective at the next clk edge.
REQ-012 MEMrq  output  1  memory request.
REQ-013 RnW  output  1  1=read, 0=write; meaningful only when MEMrq=1.
REQ-014 Halted  output  1  processor stopped.

Function
REQ-015 State machine SHALL have exactly three states: FETCH, EXEC, HALT; state is registered, outputs are combinational from state, F, N, Z, mem_ready.
REQ-016 Don't-care outputs SHALL be driven 0 (no X on any output).
REQ-017 FETCH: Addr_sel=0, MEMrq=1, RnW=1, X_sel=1, ALU_fs=10; IR_En=PC_En=mem_ready.
REQ-018 FETCH with mem_ready=0 SHALL remain in FETCH with all enables 0 (wait state, unbounded).
REQ-019 FETCH with mem_ready=1 SHALL go to EXEC next cycle.
REQ-020 EXEC F=0 LDA: Addr_sel=1, MEMrq=1, RnW=1, Y_sel=0, ALU_fs=00, Acc_En=mem_ready.
REQ-021 EXEC F=1 STA: Addr_sel=1, MEMrq=1, RnW=0, no enables.
REQ-022 EXEC F=2 ADD / F=3 SUB: Addr_sel=1, MEMrq=1, RnW=1, X_sel=0, Y_sel=0, ALU_fs=01 / 11, Acc_En=mem_ready.
REQ-023 For F=0..3, EXEC with mem_ready=0 SHALL hold EXEC with all enables 0; mem_ready=1 SHALL go to FETCH.
REQ-024 EXEC F=4 JMP: MEMrq=0, Y_sel=1, ALU_fs=00, PC_En=1; next FETCH; mem_ready ignored.
REQ-025 EXEC F=5 JGE: as JMP but PC_En=~N; F=6 JNE: PC_En=~Z; next FETCH in both cases.
REQ-026 EXEC F=7 STP: no enables, MEMrq=0; next state HALT.
REQ-027 EXEC F=8..F: no-operation, all enables 0, MEMrq=0; next FETCH (1 cycle).
REQ-028 HALT: Halted=1, all enables 0, MEMrq=0; HALT is absorbing until rst_n=0.
REQ-029 Halted SHALL be 0 in FETCH and EXEC.
REQ-030 Latency: no-memory instructions SHALL take 2 cycles (FETCH+EXEC), memory instructions 2 cycles plus wait cycles.
REQ-031 mem_ready while MEMrq=0 SHALL be ignored.
REQ-032 N/Z SHALL be sampled combinationally in the JGE/JNE EXEC cycle only.

Reset
REQ-033 rst_n=0 SHALL force state to FETCH immediately, independent of clk.
REQ-034 While rst_n=0, PC_En, IR_En, Acc_En, MEMrq, Halted and all selects SHALL be 0, RnW=1, ALU_fs=00.
REQ-035 Reset asserted mid-wait or in HALT SHALL abort and restart at FETCH; first rising edge after deassertion with mem_ready=1 SHALL load IR.

Verification
REQ-036 Reset, mem_ready=1, F=0 -> cycle1 FETCH MEMrq=1 Addr_sel=0 IR_En=PC_En=1; cycle2 EXEC Addr_sel=1 Acc_En=1; cycle3 FETCH.
REQ-037 FETCH with mem_ready low 3 cycles then high -> IR_En/PC_En 0 for 3 cycles, 1 on 4th, EXEC on 5th.
REQ-038 F=5, N=1 -> EXEC PC_En=0; F=5, N=0 -> PC_En=1, Y_sel=1, ALU_fs=00; F=6, Z=1 -> PC_En=0.
REQ-039 F=1 -> EXEC MEMrq=1 RnW=0 Addr_sel=1, no enables; F=3 -> ALU_fs=11 Acc_En=1.
REQ-040 F=7 -> HALT next cycle, Halted=1 held 10 cycles with mem_ready toggling; rst_n pulse low -> Halted=0, FETCH.
REQ-041 F=9 -> single EXEC cycle, all enables 0, MEMrq=0, return to FETCH.

Source files
------------

// File: rtl/mu0_control.sv
// MU0 control unit: three-state FETCH/EXEC/HALT sequencer that drives datapath
// selects, register load enables and memory handshake for the MU0 processor.
module mu0_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       mem_ready,
    output logic       Addr_sel,
    output logic       X_sel,
    output logic       Y_sel,
    output logic [1:0] ALU_fs,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic       MEMrq,
    output logic       RnW,
    output logic       Halted
);

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StHalt  = 2'd2
    } state_e;

    localparam logic [3:0] OpLda = 4'd0;
    localparam logic [3:0] OpSta = 4'd1;
    localparam logic [3:0] OpAdd = 4'd2;
    localparam logic [3:0] OpSub = 4'd3;
    localparam logic [3:0] OpJmp = 4'd4;
    localparam logic [3:0] OpJge = 4'd5;
    localparam logic [3:0] OpJne = 4'd6;
    localparam logic [3:0] OpStp = 4'd7;

    localparam logic [1:0] FsY    = 2'b00;
    localparam logic [1:0] FsAdd  = 2'b01;
    localparam logic [1:0] FsInc  = 2'b10;
    localparam logic [1:0] FsSub  = 2'b11;

    state_e r_state;
    state_e w_state_next;
    logic   w_mem_op;

    // Opcodes 0..3 touch memory and must wait for mem_ready.
    assign w_mem_op = (F[3:2] == 2'b00);

    // Next-state decode; memory accesses stall until mem_ready.
    always_comb begin
        w_state_next = StFetch;
        unique case (r_state)
            StFetch: w_state_next = mem_ready ? StExec : StFetch;
            StExec: begin
                if (w_mem_op) begin
                    w_state_next = mem_ready ? StFetch : StExec;
                end else if (F == OpStp) begin
                    w_state_next = StHalt;
                end else begin
                    w_state_next = StFetch;
                end
            end
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StFetch;
        endcase
    end

    // State register; reset returns to FETCH asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output decode from state and live inputs; reset overrides everything.
    always_comb begin
        Addr_sel = 1'b0;
        X_sel    = 1'b0;
        Y_sel    = 1'b0;
        ALU_fs   = FsY;
        PC_En    = 1'b0;
        IR_En    = 1'b0;
        Acc_En   = 1'b0;
        MEMrq    = 1'b0;
        RnW      = 1'b0;
        Halted   = 1'b0;
        unique case (r_state)
            StFetch: begin
                // PC+1 computed while the instruction is read.
                MEMrq  = 1'b1;
                RnW    = 1'b1;
                X_sel  = 1'b1;
                ALU_fs = FsInc;
                IR_En  = mem_ready;
                PC_En  = mem_ready;
            end
            StExec: begin
                unique case (F)
                    OpLda: begin
                        Addr_sel = 1'b1;
                        MEMrq    = 1'b1;
                        RnW      = 1'b1;
                        Acc_En   = mem_ready;
                    end
                    OpSta: begin
                        Addr_sel = 1'b1;
                        MEMrq    = 1'b1;
                    end
                    OpAdd, OpSub: begin
                        Addr_sel = 1'b1;
                        MEMrq    = 1'b1;
                        RnW      = 1'b1;
                        ALU_fs   = (F == OpAdd) ? FsAdd : FsSub;
                        Acc_En   = mem_ready;
                    end
                    OpJmp, OpJge, OpJne: begin
                        // Jump target comes from IR via the Y operand.
                        Y_sel = 1'b1;
                        if (F == OpJmp) begin
                            PC_En = 1'b1;
                        end else if (F == OpJge) begin
                            PC_En = ~N;
                        end else begin
                            PC_En = ~Z;
                        end
                    end
                    default: ;
                endcase
            end
            StHalt:  Halted = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            Addr_sel = 1'b0;
            X_sel    = 1'b0;
            Y_sel    = 1'b0;
            ALU_fs   = FsY;
            PC_En    = 1'b0;
            IR_En    = 1'b0;
            Acc_En   = 1'b0;
            MEMrq    = 1'b0;
            RnW      = 1'b1;
            Halted   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mu0_control.sv
// Testbench for mu0_control: directed scenarios followed by random opcodes and
// handshakes, compared against an instruction-level model of the sequencer.
module tb_mu0_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] F = 4'd0;
    logic       N = 1'b0;
    logic       Z = 1'b0;
    logic       mem_ready = 1'b0;
    logic       Addr_sel, X_sel, Y_sel, PC_En, IR_En, Acc_En, MEMrq, RnW, Halted;
    logic [1:0] ALU_fs;

    int checks = 0;
    int errors = 0;

    // Model phase: 0 = fetching an instruction, 1 = executing it, 2 = stopped.
    int phase = 0;

    mu0_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .F         (F),
        .N         (N),
        .Z         (Z),
        .mem_ready (mem_ready),
        .Addr_sel  (Addr_sel),
        .X_sel     (X_sel),
        .Y_sel     (Y_sel),
        .ALU_fs    (ALU_fs),
        .PC_En     (PC_En),
        .IR_En     (IR_En),
        .Acc_En    (Acc_En),
        .MEMrq     (MEMrq),
        .RnW       (RnW),
        .Halted    (Halted)
    );

    always #5 clk = ~clk;

    // Output bundle order: Addr_sel X_sel Y_sel ALU_fs[1:0] PC_En IR_En Acc_En MEMrq RnW Halted
    function automatic logic [10:0] pack(input logic a, x, y, input logic [1:0] fs,
                                         input logic pc, ir, acc, mem, rnw, h);
        return {a, x, y, fs, pc, ir, acc, mem, rnw, h};
    endfunction

    function automatic logic [10:0] observed();
        return pack(Addr_sel, X_sel, Y_sel, ALU_fs, PC_En, IR_En, Acc_En, MEMrq, RnW, Halted);
    endfunction

    // Expected outputs from the instruction semantics of MU0.
    function automatic logic [10:0] expected(input int ph, input logic rst,
                                             input logic [3:0] f, input logic n, z, mr);
        if (!rst) return pack(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        if (ph == 2) return pack(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        if (ph == 0) return pack(0, 1, 0, 2'b10, mr, mr, 0, 1, 1, 0);
        case (f)
            4'd0: return pack(1, 0, 0, 2'b00, 0, 0, mr, 1, 1, 0);
            4'd1: return pack(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
            4'd2: return pack(1, 0, 0, 2'b01, 0, 0, mr, 1, 1, 0);
            4'd3: return pack(1, 0, 0, 2'b11, 0, 0, mr, 1, 1, 0);
            4'd4: return pack(0, 0, 1, 2'b00, 1, 0, 0, 0, 0, 0);
            4'd5: return pack(0, 0, 1, 2'b00, !n, 0, 0, 0, 0, 0);
            4'd6: return pack(0, 0, 1, 2'b00, !z, 0, 0, 0, 0, 0);
            default: return pack(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    function automatic int next_phase(input int ph, input logic [3:0] f, input logic mr);
        if (ph == 2) return 2;
        if (ph == 0) return mr ? 1 : 0;
        if (f <= 4'd3) return mr ? 0 : 1;
        if (f == 4'd7) return 2;
        return 0;
    endfunction

    task automatic check(input string tag);
        logic [10:0] exp_v;
        logic [10:0] obs_v;
        exp_v = expected(phase, rst_n, F, N, Z, mem_ready);
        obs_v = observed();
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (phase %0d F %0d)",
                   tag, obs_v, exp_v, phase, F);
        end
    endtask

    // Called just after a rising edge: apply inputs, check mid-cycle, advance.
    task automatic step(input string tag, input logic [3:0] f, input logic n, z, mr);
        F = f;
        N = n;
        Z = z;
        mem_ready = mr;
        #3;
        check(tag);
        phase = next_phase(phase, f, mr);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse starting mid-cycle.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        phase = 0;
        check(tag);
        @(posedge clk);
        #1;
        check(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        #2;
        check("reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // LDA with immediate ready
        step("lda_fetch", 4'd0, 0, 0, 1);
        step("lda_exec", 4'd0, 0, 0, 1);
        step("lda_back_fetch", 4'd0, 0, 0, 1);
        step("after_lda_exec", 4'd0, 0, 0, 1);

        // Fetch wait states
        for (int i = 0; i < 3; i++) step("fetch_wait", 4'd2, 0, 0, 0);
        step("fetch_ready", 4'd2, 0, 0, 1);
        step("add_wait", 4'd2, 0, 0, 0);
        step("add_exec", 4'd2, 0, 0, 1);

        // Conditional jumps
        step("f_jge", 4'd5, 1, 0, 1);
        step("jge_n1", 4'd5, 1, 0, 0);
        step("f_jge2", 4'd5, 0, 0, 1);
        step("jge_n0", 4'd5, 0, 1, 1);
        step("f_jne", 4'd6, 0, 1, 1);
        step("jne_z1", 4'd6, 0, 1, 1);
        step("f_jne2", 4'd6, 1, 0, 1);
        step("jne_z0", 4'd6, 1, 0, 0);

        // STA and SUB
        step("f_sta", 4'd1, 0, 0, 1);
        step("sta_exec", 4'd1, 0, 0, 1);
        step("f_sub", 4'd3, 0, 0, 1);
        step("sub_exec", 4'd3, 0, 0, 1);

        // NOP opcode
        step("f_nop", 4'd9, 0, 0, 1);
        step("nop_exec", 4'd9, 0, 0, 0);
        step("nop_back_fetch", 4'd9, 0, 0, 0);
        step("nop_fetch_go", 4'd7, 0, 0, 1);

        // STP then HALT absorbing with mem_ready toggling
        step("stp_exec", 4'd7, 0, 0, 1);
        for (int i = 0; i < 10; i++) step("halt_hold", 4'($urandom_range(0, 15)), 0, 0, 1'(i));
        pulse_reset("reset_in_halt");
        step("post_reset_fetch", 4'd0, 0, 0, 1);

        // Reset during an EXEC wait state
        step("wait_exec", 4'd0, 0, 0, 0);
        pulse_reset("reset_in_wait");
        step("post_reset_fetch2", 4'd4, 0, 0, 1);

        // Random instruction stream with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ((phase == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0) begin
                pulse_reset("rand_reset");
            end else begin
                step("rand", 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                     1'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
